// File: rtl/semafor_ctrl.sv
// Traffic-light sequencer: runs the lamp cycle and applies UART commands only at safe points.
// Optional pedestrian request/walk support is enabled by defining SEMAFOR_PED_EN.
module semafor_ctrl #(
    parameter int T_RED         = 32,
    parameter int T_RED_YEL     = 8,
    parameter int T_GREEN       = 32,
    parameter int T_GREEN_BLINK = 16,
    parameter int T_YELLOW      = 8,
    parameter int BLINK_HALF    = 4,
    parameter int CNT_W         = 8
) (
    input  logic       rxclk,
    input  logic       reset,
    input  logic [1:0] cmd_data,
    input  logic       cmd_valid,
`ifdef SEMAFOR_PED_EN
    input  logic       ped_req,
    output logic       ped_walk,
`endif
    output logic       lamp_red,
    output logic       lamp_yel,
    output logic       lamp_grn,
    output logic [1:0] mode,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_RED,
        S_RED_YEL,
        S_GREEN,
        S_GREEN_BLINK,
        S_YELLOW,
        S_OFF,
        S_FLASH
    } state_t;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_RUN   = 2'b01;
    localparam logic [1:0] MODE_STOP  = 2'b10;
    localparam logic [1:0] MODE_FLASH = 2'b11;

    localparam logic [CNT_W-1:0] LD_RED   = CNT_W'(T_RED - 1);
    localparam logic [CNT_W-1:0] LD_RY    = CNT_W'(T_RED_YEL - 1);
    localparam logic [CNT_W-1:0] LD_GREEN = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] LD_GB    = CNT_W'(T_GREEN_BLINK - 1);
    localparam logic [CNT_W-1:0] LD_YEL   = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] LD_BLINK = CNT_W'(BLINK_HALF - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_on_q, blink_on_d;
    logic [1:0]       mode_q, mode_d;
    logic [1:0]       pend_q, pend_d;
    logic             busy_q, busy_d;
    logic [2:0]       lamp_q, lamp_d;

    logic             enter;
    logic             expired;
    logic             apply_req;
    logic [CNT_W-1:0] timer_dec;
    state_t           apply_state;
    logic [CNT_W-1:0] apply_timer;

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            state_q     <= S_RED;
            timer_q     <= '0;
            blink_cnt_q <= LD_BLINK;
            blink_on_q  <= 1'b1;
            mode_q      <= MODE_STOP;
            pend_q      <= MODE_OFF;
            busy_q      <= 1'b0;
            lamp_q      <= 3'b100;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            mode_q      <= mode_d;
            pend_q      <= pend_d;
            busy_q      <= busy_d;
            lamp_q      <= lamp_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        mode_d      = mode_q;
        pend_d      = pend_q;
        busy_d      = busy_q;
        enter       = 1'b0;
        expired     = (timer_q == '0);
        timer_dec   = expired ? timer_q : timer_q - 1'b1;
        apply_req   = busy_q && (pend_q != mode_q);
        apply_state = S_RED;
        apply_timer = '0;

        // Where a pending command lands once the lamps are at a safe point.
        case (pend_q)
            MODE_OFF:   apply_state = S_OFF;
            MODE_FLASH: apply_state = S_FLASH;
            MODE_RUN:   apply_timer = LD_RED;
            default:    apply_timer = '0;
        endcase

        if (busy_q && !apply_req) begin
            busy_d = 1'b0;
        end

        case (state_q)
            S_RED: begin
                if (apply_req) begin
                    state_d = apply_state;
                    timer_d = apply_timer;
                    mode_d  = pend_q;
                    busy_d  = 1'b0;
                    enter   = 1'b1;
                end else if (mode_q == MODE_RUN) begin
                    if (expired) begin
                        state_d = S_RED_YEL;
                        timer_d = LD_RY;
                        enter   = 1'b1;
                    end else begin
                        timer_d = timer_dec;
                    end
                end
            end
            S_RED_YEL: begin
                if (apply_req) begin
                    state_d = S_RED;
                    timer_d = LD_RED;
                    enter   = 1'b1;
                end else if (expired) begin
                    state_d = S_GREEN;
                    timer_d = LD_GREEN;
                    enter   = 1'b1;
                end else begin
                    timer_d = timer_dec;
                end
            end
            S_GREEN: begin
                if (apply_req) begin
                    state_d = S_YELLOW;
                    timer_d = LD_YEL;
                    enter   = 1'b1;
                end else if (expired) begin
                    state_d = S_GREEN_BLINK;
                    timer_d = LD_GB;
                    enter   = 1'b1;
                end else begin
`ifdef SEMAFOR_PED_EN
                    timer_d = (ped_req && (timer_dec > LD_BLINK)) ? LD_BLINK : timer_dec;
`else
                    timer_d = timer_dec;
`endif
                end
            end
            S_GREEN_BLINK: begin
                if (apply_req || expired) begin
                    state_d = S_YELLOW;
                    timer_d = LD_YEL;
                    enter   = 1'b1;
                end else begin
                    timer_d = timer_dec;
                end
            end
            S_YELLOW: begin
                if (expired) begin
                    state_d = S_RED;
                    timer_d = LD_RED;
                    enter   = 1'b1;
                end else begin
                    timer_d = timer_dec;
                end
            end
            S_OFF, S_FLASH: begin
                if (apply_req) begin
                    state_d = apply_state;
                    timer_d = apply_timer;
                    mode_d  = pend_q;
                    busy_d  = 1'b0;
                    enter   = 1'b1;
                end
            end
            default: begin
                state_d = S_RED;
                timer_d = '0;
                enter   = 1'b1;
            end
        endcase

        // A fresh command always wins over any clear made above on this edge.
        if (cmd_valid) begin
            pend_d = cmd_data;
            busy_d = 1'b1;
        end

        if (enter) begin
            blink_cnt_d = LD_BLINK;
            blink_on_d  = 1'b1;
        end else if (blink_cnt_q == '0) begin
            blink_cnt_d = LD_BLINK;
            blink_on_d  = ~blink_on_q;
        end else begin
            blink_cnt_d = blink_cnt_q - 1'b1;
            blink_on_d  = blink_on_q;
        end

        case (state_d)
            S_RED:         lamp_d = 3'b100;
            S_RED_YEL:     lamp_d = 3'b110;
            S_GREEN:       lamp_d = 3'b001;
            S_GREEN_BLINK: lamp_d = {2'b00, blink_on_d};
            S_YELLOW:      lamp_d = 3'b010;
            S_FLASH:       lamp_d = {1'b0, blink_on_d, 1'b0};
            default:       lamp_d = 3'b000;
        endcase
    end

`ifdef SEMAFOR_PED_EN
    logic ped_walk_q, ped_walk_d;

    always_comb begin
        ped_walk_d = (state_d == S_RED) && (mode_d == MODE_RUN);
    end

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            ped_walk_q <= 1'b0;
        end else begin
            ped_walk_q <= ped_walk_d;
        end
    end

    assign ped_walk = ped_walk_q;
`endif

    assign lamp_red = lamp_q[2];
    assign lamp_yel = lamp_q[1];
    assign lamp_grn = lamp_q[0];
    assign mode     = mode_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_semafor_ctrl.sv
// Self-checking bench for semafor_ctrl: directed scenarios plus random commands,
// compared every cycle against a cycle-age based model of the lamp sequence.
module tb_semafor_ctrl;

    localparam int TR  = 8;
    localparam int TRY = 2;
    localparam int TG  = 6;
    localparam int TGB = 4;
    localparam int TY  = 3;
    localparam int BH  = 1;

    localparam int P_RED   = 0;
    localparam int P_RY    = 1;
    localparam int P_G     = 2;
    localparam int P_GB    = 3;
    localparam int P_Y     = 4;
    localparam int P_OFF   = 5;
    localparam int P_FLASH = 6;

    localparam logic [1:0] C_OFF   = 2'b00;
    localparam logic [1:0] C_RUN   = 2'b01;
    localparam logic [1:0] C_STOP  = 2'b10;
    localparam logic [1:0] C_FLASH = 2'b11;

    typedef struct packed {
        logic [3:0]  phase;
        logic [31:0] age;
        logic [1:0]  mode;
        logic [1:0]  pend;
        logic        busy;
    } mdl_t;

    localparam mdl_t MDL_RESET = '{phase: 4'(P_RED), age: 32'd0, mode: C_STOP, pend: C_OFF, busy: 1'b0};

    logic       rxclk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_data = 2'b00;
    logic       lamp_red, lamp_yel, lamp_grn, busy;
    logic [1:0] mode;

    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_en = 1'b0;
    mdl_t m;

    semafor_ctrl #(
        .T_RED(TR), .T_RED_YEL(TRY), .T_GREEN(TG), .T_GREEN_BLINK(TGB),
        .T_YELLOW(TY), .BLINK_HALF(BH), .CNT_W(8)
    ) dut (
        .rxclk(rxclk), .reset(reset), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
        .lamp_red(lamp_red), .lamp_yel(lamp_yel), .lamp_grn(lamp_grn),
        .mode(mode), .busy(busy)
    );

    always #5 rxclk = ~rxclk;

    function automatic int dur(input int ph);
        case (ph)
            P_RED:   return TR;
            P_RY:    return TRY;
            P_G:     return TG;
            P_GB:    return TGB;
            P_Y:     return TY;
            default: return 0;
        endcase
    endfunction

    function automatic mdl_t model_next(input mdl_t s, input logic v, input logic [1:0] d);
        mdl_t n;
        bit   enter;
        bit   timed;
        bit   done;
        int   ph;
        n     = s;
        enter = 1'b0;
        ph    = int'(s.phase);
        timed = (ph == P_RED) ? (s.mode == C_RUN) : (ph >= P_RY && ph <= P_Y);
        done  = timed && (int'(s.age) >= dur(ph) - 1);
        if (s.busy && s.pend != s.mode) begin
            if (ph == P_RY) begin
                n.phase = 4'(P_RED);
                enter   = 1'b1;
            end else if (ph == P_G || ph == P_GB) begin
                n.phase = 4'(P_Y);
                enter   = 1'b1;
            end else if (ph == P_Y) begin
                if (done) begin
                    n.phase = 4'(P_RED);
                    enter   = 1'b1;
                end
            end else begin
                n.mode = s.pend;
                n.busy = 1'b0;
                enter  = 1'b1;
                if (s.pend == C_OFF) n.phase = 4'(P_OFF);
                else if (s.pend == C_FLASH) n.phase = 4'(P_FLASH);
                else n.phase = 4'(P_RED);
            end
        end else begin
            n.busy = 1'b0;
            if (done) begin
                enter   = 1'b1;
                n.phase = (ph == P_Y) ? 4'(P_RED) : 4'(ph + 1);
            end
        end
        n.age = enter ? 32'd0 : s.age + 32'd1;
        if (v) begin
            n.pend = d;
            n.busy = 1'b1;
        end
        return n;
    endfunction

    function automatic logic [2:0] exp_lamps(input mdl_t s);
        logic on;
        on = ((int'(s.age) / BH) % 2) == 0;
        case (int'(s.phase))
            P_RED:   return 3'b100;
            P_RY:    return 3'b110;
            P_G:     return 3'b001;
            P_GB:    return {2'b00, on};
            P_Y:     return 3'b010;
            P_FLASH: return {1'b0, on, 1'b0};
            default: return 3'b000;
        endcase
    endfunction

    always @(posedge rxclk or posedge reset) begin
        if (reset) m <= MDL_RESET;
        else m <= model_next(m, cmd_valid, cmd_data);
    end

    task automatic checkOutput(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic checkLamps(input string name, input logic [2:0] exp);
        checkOutput(name, {lamp_red, lamp_yel, lamp_grn}, exp);
    endtask

    always @(negedge rxclk) begin
        if (chk_en && !reset) begin
            checkOutput("model_lamps", {lamp_red, lamp_yel, lamp_grn}, exp_lamps(m));
            checkOutput("model_mode", {1'b0, mode}, {1'b0, m.mode});
            checkOutput("model_busy", {2'b00, busy}, {2'b00, m.busy});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge rxclk);
    endtask

    // Called at a negedge; returns at the negedge following the sampling edge.
    task automatic applyStimulus(input logic [1:0] c);
        cmd_valid = 1'b1;
        cmd_data  = c;
        @(negedge rxclk);
        cmd_valid = 1'b0;
    endtask

    task automatic waitPhase(input int ph, input int age, input int budget);
        int k = 0;
        while (!(int'(m.phase) == ph && int'(m.age) == age) && k < budget) begin
            @(negedge rxclk);
            k++;
        end
        n_checks++;
        if (k >= budget) begin
            n_errors++;
            $display("[TB] FAIL wait_phase: phase %0d age %0d not reached within %0d cycles, got phase %0d", ph, age, budget, m.phase);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [2:0] seq[$];
        int r;

        repeat (3) @(negedge rxclk);
        reset  = 1'b0;
        chk_en = 1'b1;

        checkLamps("reset_lamps", 3'b100);
        checkOutput("reset_mode", {1'b0, mode}, 3'b010);
        checkOutput("reset_busy", {2'b00, busy}, 3'b000);
        tick(20);
        checkLamps("idle_lamps", 3'b100);

        applyStimulus(C_RUN);
        checkOutput("run_busy", {2'b00, busy}, 3'b001);
        checkOutput("run_mode_before", {1'b0, mode}, 3'b010);
        tick(1);
        checkOutput("run_mode", {1'b0, mode}, 3'b001);
        checkOutput("run_busy_clear", {2'b00, busy}, 3'b000);
        repeat (TR) seq.push_back(3'b100);
        repeat (TRY) seq.push_back(3'b110);
        repeat (TG) seq.push_back(3'b001);
        seq.push_back(3'b001);
        seq.push_back(3'b000);
        seq.push_back(3'b001);
        seq.push_back(3'b000);
        repeat (TY) seq.push_back(3'b010);
        seq.push_back(3'b100);
        foreach (seq[i]) begin
            checkLamps("run_sequence", seq[i]);
            tick(1);
        end

        waitPhase(P_G, 1, 100);
        applyStimulus(C_STOP);
        checkLamps("stop_still_green", 3'b001);
        checkOutput("stop_busy", {2'b00, busy}, 3'b001);
        for (int i = 0; i < TY; i++) begin
            tick(1);
            checkLamps("stop_yellow", 3'b010);
        end
        tick(1);
        checkLamps("stop_red_entry", 3'b100);
        checkOutput("stop_mode_pending", {1'b0, mode}, 3'b001);
        tick(1);
        checkOutput("stop_mode", {1'b0, mode}, 3'b010);
        checkOutput("stop_busy_clear", {2'b00, busy}, 3'b000);
        tick(12);
        checkLamps("stop_hold", 3'b100);

        applyStimulus(C_FLASH);
        tick(1);
        checkOutput("flash_mode", {1'b0, mode}, 3'b011);
        for (int i = 0; i < 4; i++) begin
            checkLamps("flash_toggle", (i % 2 == 0) ? 3'b010 : 3'b000);
            tick(1);
        end
        applyStimulus(C_OFF);
        tick(1);
        checkLamps("off_lamps", 3'b000);
        checkOutput("off_mode", {1'b0, mode}, 3'b000);
        tick(5);

        applyStimulus(C_RUN);
        waitPhase(P_RY, 0, 100);
        cmd_valid = 1'b1;
        cmd_data  = C_OFF;
        @(negedge rxclk);
        cmd_data  = C_FLASH;
        @(negedge rxclk);
        cmd_valid = 1'b0;
        checkLamps("ry_abort_red", 3'b100);
        checkOutput("ry_abort_mode", {1'b0, mode}, 3'b001);
        tick(1);
        checkLamps("ry_flash_lamps", 3'b010);
        checkOutput("ry_flash_mode", {1'b0, mode}, 3'b011);
        checkOutput("ry_flash_busy", {2'b00, busy}, 3'b000);

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                r         = int'($urandom_range(0, 7));
                cmd_valid = 1'b1;
                cmd_data  = (r < 4) ? C_RUN : 2'(r - 4);
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge rxclk);
        end
        cmd_valid = 1'b0;

        applyStimulus(C_RUN);
        waitPhase(P_G, 2, 200);
        cmd_valid = 1'b1;
        cmd_data  = C_FLASH;
        @(posedge rxclk);
        #2;
        cmd_valid = 1'b0;
        reset     = 1'b1;
        #1;
        checkOutput("async_reset_red", {2'b00, lamp_red}, 3'b001);
        checkOutput("async_reset_grn", {2'b00, lamp_grn}, 3'b000);
        checkOutput("async_reset_busy", {2'b00, busy}, 3'b000);
        checkOutput("async_reset_mode", {1'b0, mode}, 3'b010);
        @(negedge rxclk);
        reset = 1'b0;
        tick(10);
        checkLamps("reset_pend_lost", 3'b100);
        checkOutput("reset_pend_mode", {1'b0, mode}, 3'b010);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
